// File: rtl/x2050_ibq.sv
// x2050_ibq: halfword instruction buffer queue fed by word fetches, with fetch sequencer and status.
// Optional X2050_IBQ_BYPASS_EN presents acked fetch data at the head in the ack cycle when the queue is empty.
module x2050_ibq #(
  parameter int unsigned PTR_W = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ros_advance,
  input  logic             i_flush,
  input  logic [23:0]      i_new_iar,
  output logic             o_fetch_req,
  output logic [23:0]      o_fetch_addr,
  input  logic             i_fetch_ack,
  input  logic [31:0]      i_fetch_data,
  input  logic             i_invalid_address,
  input  logic             i_consume,
  output logic [47:0]      o_op,
  output logic [1:0]       o_ilc,
  output logic             o_op_ready,
  output logic [PTR_W:0]   o_count,
  output logic             o_ibfull,
  output logic             o_refetch_stat,
  output logic             o_one_syllable_op_stat,
  output logic [1:0]       o_fetch_stat_fcn
);

  localparam int unsigned DEPTH = 2 ** PTR_W;
  localparam int unsigned CW    = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_FAULT} state_t;

  state_t           state;
  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             odd_start;
  logic             flush_q;
  logic             wr_en;
  logic             cons_ok;
  logic [CW-1:0]    free_c;
  logic [CW-1:0]    wr_n;
  logic [CW-1:0]    rm_n;
  logic [CW-1:0]    view_cnt;
  logic [47:0]      head;
  logic             unused_iar0;

  assign unused_iar0 = i_new_iar[0];
  assign flush_q     = i_ros_advance & i_flush;
  assign free_c      = CW'(DEPTH) - o_count;
  assign o_ibfull    = free_c < CW'(2);
  assign wr_en       = (state == S_REQ) & i_fetch_ack & ~i_invalid_address & ~flush_q;
  assign wr_n        = wr_en ? (odd_start ? CW'(1) : CW'(2)) : CW'(0);

  // Head window: three halfwords from rd_ptr, or the incoming word when bypassing an empty queue
  always_comb begin
    head     = {mem[rd_ptr], mem[rd_ptr + PTR_W'(1)], mem[rd_ptr + PTR_W'(2)]};
    view_cnt = o_count;
`ifdef X2050_IBQ_BYPASS_EN
    if (o_count == '0 && wr_en) begin
      head     = odd_start ? {i_fetch_data[15:0], 32'h0} : {i_fetch_data, 16'h0};
      view_cnt = wr_n;
    end
`endif
  end

  assign o_op = head;

  always_comb begin
    case (head[47:46])
      2'b00:   o_ilc = 2'd1;
      2'b11:   o_ilc = 2'd3;
      default: o_ilc = 2'd2;
    endcase
  end

  assign o_op_ready = (view_cnt != '0) && (view_cnt >= CW'(o_ilc));
  assign cons_ok    = i_ros_advance & i_consume & ~flush_q & o_op_ready;
  assign rm_n       = cons_ok ? CW'(o_ilc) : CW'(0);

  // Occupancy, pointers and retire status
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_count                <= '0;
      rd_ptr                 <= '0;
      wr_ptr                 <= '0;
      o_one_syllable_op_stat <= 1'b0;
    end else if (flush_q) begin
      o_count                <= '0;
      rd_ptr                 <= '0;
      wr_ptr                 <= '0;
      o_one_syllable_op_stat <= 1'b0;
    end else begin
      o_count <= o_count - rm_n + wr_n;
      rd_ptr  <= rd_ptr + PTR_W'(rm_n);
      wr_ptr  <= wr_ptr + PTR_W'(wr_n);
      if (cons_ok) o_one_syllable_op_stat <= (o_ilc == 2'd1);
    end
  end

  // Halfword storage; big-endian word, so [31:16] is the lower address
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      if (odd_start) begin
        mem[wr_ptr] <= i_fetch_data[15:0];
      end else begin
        mem[wr_ptr]               <= i_fetch_data[31:16];
        mem[wr_ptr + PTR_W'(1)]   <= i_fetch_data[15:0];
      end
    end
  end

  function automatic logic [1:0] idle_fcn(input logic odd);
    return odd ? 2'd0 : 2'd2;
  endfunction

  // Fetch sequencer with registered request and status outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state            <= S_IDLE;
      o_fetch_req      <= 1'b0;
      o_fetch_addr     <= '0;
      odd_start        <= 1'b0;
      o_refetch_stat   <= 1'b0;
      o_fetch_stat_fcn <= 2'd2;
    end else if (flush_q) begin
      o_fetch_addr <= {i_new_iar[23:2], 2'b00};
      odd_start    <= i_new_iar[1];
      if ((state == S_REQ || state == S_DROP) && !i_fetch_ack) begin
        state            <= S_DROP;
        o_fetch_req      <= 1'b1;
        o_refetch_stat   <= 1'b1;
        o_fetch_stat_fcn <= 2'd1;
      end else begin
        state            <= S_IDLE;
        o_fetch_req      <= 1'b0;
        o_refetch_stat   <= 1'b0;
        o_fetch_stat_fcn <= idle_fcn(i_new_iar[1]);
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (free_c >= (odd_start ? CW'(1) : CW'(2))) begin
            state       <= S_REQ;
            o_fetch_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (i_fetch_ack) begin
            o_fetch_req <= 1'b0;
            if (i_invalid_address) begin
              state            <= S_FAULT;
              o_fetch_stat_fcn <= 2'd3;
            end else begin
              state            <= S_IDLE;
              o_fetch_addr     <= o_fetch_addr + 24'd4;
              odd_start        <= 1'b0;
              o_fetch_stat_fcn <= 2'd2;
            end
          end
        end
        S_DROP: begin
          if (i_fetch_ack) begin
            state            <= S_IDLE;
            o_fetch_req      <= 1'b0;
            o_refetch_stat   <= 1'b0;
            o_fetch_stat_fcn <= idle_fcn(odd_start);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_x2050_ibq.sv
// tb_x2050_ibq: directed and randomized checks of x2050_ibq against a halfword-queue reference model.
// Compile with X2050_IBQ_BYPASS_EN defined to check the bypass build.
module tb_x2050_ibq;
  localparam int unsigned PW    = 2;
  localparam int unsigned DEPTH = 2 ** PW;

  logic        i_clk = 1'b0;
  logic        i_reset, i_ros_advance, i_flush, i_fetch_ack, i_invalid_address, i_consume;
  logic [23:0] i_new_iar;
  logic [31:0] i_fetch_data;
  logic        o_fetch_req;
  logic [23:0] o_fetch_addr;
  logic [47:0] o_op;
  logic [1:0]  o_ilc;
  logic        o_op_ready;
  logic [PW:0] o_count;
  logic        o_ibfull, o_refetch_stat, o_one_syllable_op_stat;
  logic [1:0]  o_fetch_stat_fcn;

  int n_cmp = 0;
  int n_bad = 0;

  x2050_ibq #(.PTR_W(PW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ros_advance(i_ros_advance), .i_flush(i_flush),
    .i_new_iar(i_new_iar), .o_fetch_req(o_fetch_req), .o_fetch_addr(o_fetch_addr),
    .i_fetch_ack(i_fetch_ack), .i_fetch_data(i_fetch_data), .i_invalid_address(i_invalid_address),
    .i_consume(i_consume), .o_op(o_op), .o_ilc(o_ilc), .o_op_ready(o_op_ready), .o_count(o_count),
    .o_ibfull(o_ibfull), .o_refetch_stat(o_refetch_stat),
    .o_one_syllable_op_stat(o_one_syllable_op_stat), .o_fetch_stat_fcn(o_fetch_stat_fcn)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of halfwords plus the outstanding-fetch bookkeeping
  logic [15:0] mq[$];
  logic [15:0] vq[$];
  bit          m_busy, m_stale, m_fault, m_odd, m_one, m_ready;
  logic [23:0] m_addr;
  int unsigned m_ilc;

  function automatic int unsigned len_of(input logic [15:0] hw);
    case (hw[15:14])
      2'b00:   return 1;
      2'b11:   return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_stale = 0; m_fault = 0; m_odd = 0; m_one = 0;
    m_addr = '0;
  endtask

  function automatic bit writes_now();
    return m_busy && i_fetch_ack && !i_invalid_address && !(i_ros_advance && i_flush);
  endfunction

  task automatic calc_view();
    vq = mq;
`ifdef X2050_IBQ_BYPASS_EN
    if (mq.size() == 0 && writes_now()) begin
      if (!m_odd) vq.push_back(i_fetch_data[31:16]);
      vq.push_back(i_fetch_data[15:0]);
    end
`endif
    m_ilc   = (vq.size() > 0) ? len_of(vq[0]) : 1;
    m_ready = (vq.size() > 0) && (vq.size() >= m_ilc);
  endtask

  task automatic check_model();
    int free;
    calc_view();
    free = int'(DEPTH) - mq.size();
    chk("count", 48'(o_count), 48'(mq.size()));
    chk("fetch_req", 48'(o_fetch_req), 48'(m_busy || m_stale));
    chk("fetch_addr", 48'(o_fetch_addr), 48'(m_addr));
    chk("ibfull", 48'(o_ibfull), 48'(free < 2));
    chk("refetch", 48'(o_refetch_stat), 48'(m_stale));
    chk("one_syl", 48'(o_one_syllable_op_stat), 48'(m_one));
    chk("fcn", 48'(o_fetch_stat_fcn), 48'(m_fault ? 3 : m_stale ? 1 : !m_odd ? 2 : 0));
    chk("op_ready", 48'(o_op_ready), 48'(m_ready));
    if (vq.size() > 0) chk("ilc", 48'(o_ilc), 48'(m_ilc));
    for (int i = 0; i < 3 && i < vq.size(); i++)
      chk($sformatf("op%0d", i), 48'(o_op[47-16*i -: 16]), 48'(vq[i]));
  endtask

  task automatic step_model();
    bit          fl    = i_ros_advance && i_flush;
    int unsigned sz0   = mq.size();
    bit          idle0 = !m_busy && !m_stale && !m_fault;
    if (fl) begin
      mq.delete();
      m_addr  = {i_new_iar[23:2], 2'b00};
      m_odd   = i_new_iar[1];
      m_one   = 0;
      m_fault = 0;
      m_stale = (m_busy || m_stale) && !i_fetch_ack;
      m_busy  = 0;
    end else begin
      if (m_busy && i_fetch_ack) begin
        if (i_invalid_address) m_fault = 1;
        else begin
          if (!m_odd) mq.push_back(i_fetch_data[31:16]);
          mq.push_back(i_fetch_data[15:0]);
          m_addr = m_addr + 24'd4;
          m_odd  = 0;
        end
        m_busy = 0;
      end else if (m_stale && i_fetch_ack) begin
        m_stale = 0;
      end else if (idle0 && (DEPTH - sz0) >= (m_odd ? 1 : 2)) begin
        m_busy = 1;
      end
      if (i_ros_advance && i_consume && m_ready) begin
        repeat (m_ilc) void'(mq.pop_front());
        m_one = (m_ilc == 1);
      end
    end
  endtask

  task automatic idle_inputs();
    i_ros_advance = 0; i_flush = 0; i_new_iar = '0; i_consume = 0;
    i_fetch_ack = 0; i_fetch_data = '0; i_invalid_address = 0;
  endtask

  task automatic drive(input bit adv, input bit fl, input logic [23:0] iar, input bit cons,
                       input bit ack, input logic [31:0] data, input bit inv);
    @(negedge i_clk);
    i_ros_advance = adv; i_flush = fl; i_new_iar = iar; i_consume = cons;
    i_fetch_ack = ack; i_fetch_data = data; i_invalid_address = inv;
    #1;
  endtask

  task automatic finish_cycle();
    check_model();
    step_model();
    @(posedge i_clk);
    #1;
    idle_inputs();
  endtask

  task automatic cycle(input bit adv, input bit fl, input logic [23:0] iar, input bit cons,
                       input bit ack, input logic [31:0] data, input bit inv);
    drive(adv, fl, iar, cons, ack, data, inv);
    finish_cycle();
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset = 1;
    idle_inputs();
    model_reset();
    #1;
    chk("rst_count", 48'(o_count), 48'(0));
    chk("rst_fetch_req", 48'(o_fetch_req), 48'(0));
    chk("rst_fetch_addr", 48'(o_fetch_addr), 48'(0));
    chk("rst_refetch", 48'(o_refetch_stat), 48'(0));
    chk("rst_one_syl", 48'(o_one_syllable_op_stat), 48'(0));
    @(posedge i_clk);
    #1;
    i_reset = 0;
  endtask

  task automatic flush_to(input logic [23:0] iar);
    cycle(1, 1, iar, 0, 0, 32'h0, 0);
  endtask

  // Step until a live fetch request is pending, retiring any dropped request on the way
  task automatic run_until_req();
    for (int n = 0; n < 20; n++) begin
      if (o_fetch_req && !o_refetch_stat) return;
      if (o_refetch_stat) cycle(0, 0, 24'h0, 0, 1, 32'hDEAD_BEEF, 0);
      else                cycle(0, 0, 24'h0, 0, 0, 32'h0, 0);
    end
    chk("req_timeout", 48'(o_fetch_req), 48'(1));
  endtask

  initial begin
    logic        adv, fl, cons, ack, inv;
    logic [23:0] iar;
    logic [31:0] data;
    i_reset = 1;
    idle_inputs();
    model_reset();
    do_reset();

    // Even restart: full word queued, visible next cycle
    flush_to(24'h000100);
    run_until_req();
    cycle(0, 0, 24'h0, 0, 1, 32'h1A2B_5860, 0);
    chk("ex1_count", 48'(o_count), 48'(2));
    chk("ex1_head", 48'(o_op[47:32]), 48'h1A2B);
    chk("ex1_ilc", 48'(o_ilc), 48'(1));
    chk("ex1_ready", 48'(o_op_ready), 48'(1));
    cycle(1, 0, 24'h0, 1, 0, 32'h0, 0);
    chk("ex1_count_after", 48'(o_count), 48'(1));
    chk("ex1_one_syl", 48'(o_one_syllable_op_stat), 48'(1));

    // Odd restart: only the low halfword of the first word is kept
    flush_to(24'h000102);
    run_until_req();
    cycle(0, 0, 24'h0, 0, 1, 32'h47F0_C010, 0);
    chk("ex2_count", 48'(o_count), 48'(1));
    chk("ex2_head", 48'(o_op[47:32]), 48'hC010);
    chk("ex2_ilc", 48'(o_ilc), 48'(3));
    chk("ex2_ready", 48'(o_op_ready), 48'(0));
    chk("ex2_addr", 48'(o_fetch_addr), 48'h000104);

    // Flush with a request in flight: the late data is dropped
    run_until_req();
    cycle(1, 1, 24'h000200, 0, 0, 32'h0, 0);
    chk("ex3_refetch", 48'(o_refetch_stat), 48'(1));
    chk("ex3_fcn", 48'(o_fetch_stat_fcn), 48'(1));
    cycle(0, 0, 24'h0, 0, 1, 32'h1234_5678, 0);
    chk("ex3_count", 48'(o_count), 48'(0));
    chk("ex3_refetch_clr", 48'(o_refetch_stat), 48'(0));

    // Invalid address parks the fetcher until a flush
    run_until_req();
    cycle(0, 0, 24'h0, 0, 1, 32'h0, 1);
    chk("ex4_fcn", 48'(o_fetch_stat_fcn), 48'(3));
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 24'h0, 0, 0, 32'h0, 0);
      chk("ex4_no_req", 48'(o_fetch_req), 48'(0));
    end
    flush_to(24'h000300);
    chk("ex4_fcn_flush", 48'(o_fetch_stat_fcn), 48'(2));
    chk("ex4_req_flush", 48'(o_fetch_req), 48'(0));

    // Fill, stall when full, then wrap both pointers
    run_until_req();
    cycle(0, 0, 24'h0, 0, 1, 32'h4111_4222, 0);
    run_until_req();
    cycle(0, 0, 24'h0, 0, 1, 32'h4333_4444, 0);
    chk("ex5_count_full", 48'(o_count), 48'(4));
    chk("ex5_ibfull", 48'(o_ibfull), 48'(1));
    repeat (3) cycle(0, 0, 24'h0, 0, 0, 32'h0, 0);
    chk("ex5_no_req", 48'(o_fetch_req), 48'(0));
    cycle(1, 0, 24'h0, 1, 0, 32'h0, 0);
    chk("ex5_count_2", 48'(o_count), 48'(2));
    chk("ex5_head_2", 48'(o_op[47:32]), 48'h4333);
    run_until_req();
    cycle(1, 0, 24'h0, 1, 1, 32'h8555_0666, 0);
    chk("ex5_count_cw", 48'(o_count), 48'(2));
    chk("ex5_head_wrap", 48'(o_op[47:32]), 48'h8555);
    run_until_req();
    cycle(0, 0, 24'h0, 0, 1, 32'hC777_0888, 0);
    chk("ex5_count_4", 48'(o_count), 48'(4));
    chk("ex5_op_wrap", o_op, 48'h8555_0666_C777);

    // Empty queue: data visibility in the ack cycle depends on the bypass build
    flush_to(24'h000400);
    run_until_req();
    drive(0, 0, 24'h0, 0, 1, 32'h05EF_0000, 0);
`ifdef X2050_IBQ_BYPASS_EN
    chk("byp_ready_ack", 48'(o_op_ready), 48'(1));
`else
    chk("byp_ready_ack", 48'(o_op_ready), 48'(0));
`endif
    finish_cycle();
    chk("byp_ready_next", 48'(o_op_ready), 48'(1));

    // Reset with a fetch outstanding; the late ack must be ignored
    run_until_req();
    do_reset();
    cycle(0, 0, 24'h0, 0, 1, 32'h1111_2222, 0);
    chk("rst_late_ack", 48'(o_count), 48'(0));

    // Randomized traffic
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      adv  = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      cons = $urandom_range(0, 1) != 0;
      ack  = o_fetch_req ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 15) == 0);
      inv  = ack && ($urandom_range(0, 39) == 0);
      iar  = 24'($urandom);
      data = $urandom;
      cycle(adv, fl, iar, cons, ack, data, inv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
